// File: rtl/sipo_deser_hs_pkg.sv
// Shared types and constants for the sipo_deser_hs serial-to-parallel receiver.
package sipo_deser_hs_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit-order mux and bit counter for the deserializer.
// next_word is the word as it would look with the current bit shifted in.
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             s_in,
  output logic [WIDTH-1:0] shift_reg,
  output logic [WIDTH-1:0] next_word,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done
);

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign next_word = {shift_reg[WIDTH-2:0], s_in};
    end else begin : g_lsb
      assign next_word = {s_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign word_done = shift_en && (bit_cnt == CNT_W'(WIDTH - 1));

  // The register keeps the completed word after the final bit so the top
  // level can park it here while the output register is still occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= next_word;
      bit_cnt   <= word_done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deser_hs.sv
// Double-buffered serial-in parallel-out deserializer with valid/ready on both
// sides and a saturating count of cycles the serial source was held off.
module sipo_deser_hs
  import sipo_deser_hs_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   s_in,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       p_out,
  output logic                   p_valid,
  input  logic                   p_ready,
  output logic [CNT_W-1:0]       bit_cnt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_t           state;
  logic             accept;
  logic             consume;
  logic             word_done;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;

  assign accept  = s_valid && s_ready;
  assign consume = p_valid && p_ready;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CNT_W    (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (accept),
    .s_in     (s_in),
    .shift_reg(shift_reg),
    .next_word(next_word),
    .bit_cnt  (bit_cnt),
    .word_done(word_done)
  );

  // s_ready is kept as its own flop mirroring the state so it leaves the
  // block straight from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      s_ready   <= 1'b1;
      p_valid   <= 1'b0;
      p_out     <= '0;
      stall_cnt <= '0;
    end else if (clr) begin
      state     <= COLLECT;
      s_ready   <= 1'b1;
      p_valid   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (s_valid && !s_ready && (stall_cnt != STALL_CNT_MAX))
        stall_cnt <= stall_cnt + 16'd1;

      case (state)
        COLLECT: begin
          if (word_done) begin
            if (!p_valid || consume) begin
              p_out   <= next_word;
              p_valid <= 1'b1;
            end else begin
              state   <= STALL;
              s_ready <= 1'b0;
            end
          end else if (consume) begin
            p_valid <= 1'b0;
          end
        end
        STALL: begin
          // p_valid is necessarily 1 here; the parked word refills p_out.
          if (consume) begin
            p_out   <= shift_reg;
            p_valid <= 1'b1;
            state   <= COLLECT;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= COLLECT;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deser_hs.sv
// Directed bench for sipo_deser_hs: one MSB-first and one LSB-first instance
// share all inputs so bit ordering is checked on the same streams.
module tb_sipo_deser_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        s_in;
  logic        s_valid;
  logic        p_ready;

  logic        s_ready,   s_ready_l;
  logic [7:0]  p_out,     p_out_l;
  logic        p_valid,   p_valid_l;
  logic [2:0]  bit_cnt,   bit_cnt_l;
  logic [15:0] stall_cnt, stall_cnt_l;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  sipo_deser_hs #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid),
    .s_ready(s_ready), .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready),
    .bit_cnt(bit_cnt), .stall_cnt(stall_cnt)
  );

  sipo_deser_hs #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid),
    .s_ready(s_ready_l), .p_out(p_out_l), .p_valid(p_valid_l), .p_ready(p_ready),
    .bit_cnt(bit_cnt_l), .stall_cnt(stall_cnt_l)
  );

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Presents one bit for one clock edge, then leaves the bench 1 time unit past it.
  task automatic apply_stimulus(input logic b);
    s_valid = 1'b1;
    s_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) apply_stimulus(w[i]);
    s_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{word: 8'hA5, exp_msb: 8'hA5, exp_lsb: 8'hA5};
    vecs[1] = '{word: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};
    vecs[2] = '{word: 8'h3C, exp_msb: 8'h3C, exp_lsb: 8'h3C};
    vecs[3] = '{word: 8'h12, exp_msb: 8'h12, exp_lsb: 8'h48};
    vecs[4] = '{word: 8'hF0, exp_msb: 8'hF0, exp_lsb: 8'h0F};
    vecs[5] = '{word: 8'hC3, exp_msb: 8'hC3, exp_lsb: 8'hC3};

    rst = 1'b1; clr = 1'b0; s_in = 1'b0; s_valid = 1'b0; p_ready = 1'b1;
    #12;
    check_output("reset_s_ready",   16'(s_ready),   16'd1);
    check_output("reset_p_valid",   16'(p_valid),   16'd0);
    check_output("reset_p_out",     16'(p_out),     16'd0);
    check_output("reset_bit_cnt",   16'(bit_cnt),   16'd0);
    check_output("reset_stall_cnt", stall_cnt,      16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back-free single words: valid for exactly one cycle.
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].word);
      check_output($sformatf("vec%0d_p_valid", v), 16'(p_valid), 16'd1);
      check_output($sformatf("vec%0d_p_out_msb", v), 16'(p_out), 16'(vecs[v].exp_msb));
      check_output($sformatf("vec%0d_p_out_lsb", v), 16'(p_out_l), 16'(vecs[v].exp_lsb));
      idle_cycle();
      check_output($sformatf("vec%0d_p_valid_drop", v), 16'(p_valid), 16'd0);
    end

    // Two words into a blocked consumer, then drain.
    p_ready = 1'b0;
    send_word(8'h3C);
    send_word(8'hC3);
    check_output("stall_s_ready", 16'(s_ready), 16'd0);
    check_output("stall_p_out",   16'(p_out),   16'h3C);
    check_output("stall_p_valid", 16'(p_valid), 16'd1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1);
    s_valid = 1'b0;
    check_output("stall_cnt_5",      stall_cnt,       16'd5);
    check_output("stall_p_out_hold", 16'(p_out),      16'h3C);
    check_output("stall_bit_cnt",    16'(bit_cnt),    16'd0);
    p_ready = 1'b1;
    @(posedge clk); #1;
    check_output("drain_p_out_2",   16'(p_out),   16'hC3);
    check_output("drain_p_valid_2", 16'(p_valid), 16'd1);
    check_output("drain_s_ready",   16'(s_ready), 16'd1);
    @(posedge clk); #1;
    check_output("drain_p_valid_end", 16'(p_valid), 16'd0);

    // 8'h5A with random gaps; bit_cnt must hold across each gap.
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 4 && $urandom_range(1) == 0; g++) begin
        idle_cycle();
        check_output($sformatf("gap_bit_cnt_%0d", i), 16'(bit_cnt), 16'(i));
      end
      apply_stimulus(logic'((8'h5A >> (7 - i)) & 8'h01));
    end
    s_valid = 1'b0;
    check_output("gap_p_valid", 16'(p_valid), 16'd1);
    check_output("gap_p_out",   16'(p_out),   16'h5A);
    idle_cycle();

    // clr with a held word and a partial word in flight.
    p_ready = 1'b0;
    send_word(8'h81);
    check_output("clr_pre_p_valid", 16'(p_valid), 16'd1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1);
    check_output("clr_pre_bit_cnt", 16'(bit_cnt), 16'd5);
    clr = 1'b1;
    apply_stimulus(1'b1);
    clr = 1'b0;
    s_valid = 1'b0;
    check_output("clr_bit_cnt",   16'(bit_cnt), 16'd0);
    check_output("clr_p_valid",   16'(p_valid), 16'd0);
    check_output("clr_p_out",     16'(p_out),   16'h81);
    check_output("clr_stall_cnt", stall_cnt,    16'd0);
    p_ready = 1'b1;
    send_word(8'hFF);
    check_output("post_clr_p_out",   16'(p_out),   16'hFF);
    check_output("post_clr_p_out_l", 16'(p_out_l), 16'hFF);
    idle_cycle();
    check_output("post_clr_p_valid", 16'(p_valid), 16'd0);

    // Asynchronous reset in the middle of a STALL.
    p_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0);
    check_output("pre_rst_stall_cnt", stall_cnt,    16'd3);
    check_output("pre_rst_s_ready",   16'(s_ready), 16'd0);
    #3 rst = 1'b1;
    #1;
    check_output("arst_s_ready",   16'(s_ready), 16'd1);
    check_output("arst_p_valid",   16'(p_valid), 16'd0);
    check_output("arst_p_out",     16'(p_out),   16'd0);
    check_output("arst_stall_cnt", stall_cnt,    16'd0);
    check_output("arst_bit_cnt",   16'(bit_cnt), 16'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    p_ready = 1'b1;
    @(posedge clk); #1;
    send_word(8'h69);
    check_output("post_rst_p_valid", 16'(p_valid), 16'd1);
    check_output("post_rst_p_out",   16'(p_out),   16'h69);
    check_output("post_rst_p_out_l", 16'(p_out_l), 16'h96);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser_hs.md
Name: sipo_deser_hs

Overview:
- Serial-in, parallel-out deserializer. It is the receive-side counterpart of the team's mux-fed flop storage and serial-shift blocks.
- Collects a 1-bit stream, qualified by valid/ready, into WIDTH-bit words.
- Presents each word on a registered parallel output with its own valid/ready handshake.
- Double-buffered: a shift register plus an output register, so the next word can be collected while the current word waits for its consumer.

Parameters:
- WIDTH, 8: bits per word. Must be 2 or more.
- MSB_FIRST, 1: 1 = first serial bit lands in p_out[WIDTH-1]; 0 = first bit lands in p_out[0].
- CNT_W, $clog2(WIDTH): width of the bit counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; discards the partial word and the held word.
- s_in  in  1  serial data bit.
- s_valid  in  1  s_in is valid this cycle.
- s_ready  out  1  block accepts s_in this cycle. A bit is accepted when s_valid & s_ready.
- p_out  out  WIDTH  assembled parallel word, registered.
- p_valid  out  1  p_out holds an unconsumed word.
- p_ready  in  1  consumer takes p_out this cycle. A word is consumed when p_valid & p_ready.
- bit_cnt  out  CNT_W  number of bits accepted into the current partial word.
- stall_cnt  out  16  saturating count of cycles with s_valid=1 and s_ready=0.

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - state=COLLECT, s_ready=1, p_valid=0, p_out=0, bit_cnt=0, shift register=0, stall_cnt=0.
- States:
  - COLLECT (s_ready=1).
  - STALL (s_ready=0): shift register holds a complete word and the output register is occupied.
- COLLECT, on each accepted bit:
  - MSB_FIRST=1: shift left, new bit enters bit 0.
  - MSB_FIRST=0: shift right, new bit enters bit WIDTH-1.
  - bit_cnt increments.
- Word completion: the accepted bit arrives while bit_cnt==WIDTH-1.
  - bit_cnt wraps to 0.
  - If p_valid==0 or the output is consumed in the same cycle: load the completed word into p_out and set p_valid=1 on the next edge. Latency is 1 cycle from the last accepted bit to p_valid=1.
  - Otherwise: store the completed word in the shift register and go to STALL.
- STALL:
  - s_ready=0; s_in is ignored.
  - On the cycle the held word is consumed, transfer the shift register to p_out, keep p_valid=1 and return to COLLECT. s_ready=1 from the following cycle.
- p_valid:
  - Clears on the edge after consumption unless a new word loads on that same edge.
  - Back-to-back words with p_ready held at 1 give no bubble: one bit per cycle sustained.
- Simultaneous consume and completion: consumption and load happen together; p_valid stays 1 with the new data.
- p_out is stable while p_valid=1 and p_ready=0.
- stall_cnt increments when s_valid=1 and s_ready=0, saturates at 16'hFFFF, and is cleared by rst or clr.
- clr priority:
  - clr has priority over all events in its cycle.
  - Next-state values: state=COLLECT, bit_cnt=0, p_valid=0, shift register=0. p_out keeps its value but is invalid.
  - Bits and words presented in the clr cycle are dropped.
- rst mid-word or mid-STALL: all state is lost immediately, with no glitch-free requirement on outputs during reset.
- s_valid gaps are allowed at any point; bit_cnt and the shift register hold across gaps.

Decomposition:
- Shared package holds:
  - the state enum {COLLECT, STALL};
  - the stall counter width constant, 16;
  - the saturating max constant.
- One natural sub-module: sipo_shift_core. It contains the shift register, the MSB_FIRST direction mux and bit_cnt, and exposes a "word_done" pulse.
- The top level owns the FSM, the output register, the handshakes and stall_cnt.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, p_ready=1, send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> p_out=8'hA5 and p_valid=1 for exactly 1 cycle, one cycle after the 8th bit.
2. Same stream with MSB_FIRST=0 -> p_out=8'hA5 reversed, i.e. 8'hA5 bit-reversed = 8'hA5 (palindrome). Then send 8'h01 MSB-first order -> p_out=8'h80.
3. p_ready=0, stream two words 8'h3C then 8'hC3 continuously -> after the second word s_ready=0 and the state is STALL; stall_cnt counts the cycles with s_valid held at 1. Assert p_ready -> p_out shows 8'h3C then 8'hC3 on consecutive handshakes.
4. Random s_valid gaps (~50%) while streaming 8'h5A -> p_out=8'h5A and bit_cnt holds during gaps.
5. After 5 accepted bits assert clr for 1 cycle -> bit_cnt=0 and p_valid=0. Then a full 8'hFF stream -> p_out=8'hFF with no stale bits.
6. Assert rst asynchronously, mid-cycle, during STALL -> immediately s_ready=1, p_valid=0, p_out=0 and stall_cnt=0. The next word is received correctly.
